div_seq: RTL and testbench
==========================

# div_seq

Sequential signed fixed-point divider used by the EKF datapath to form scaled quotients such as gain terms and innovation normalisation. It is the inverse operation of the single-cycle sign-magnitude multiplier. It computes q = trunc((a · 2^FRAC_SHIFT) / b) with a radix-2 restoring iteration, one quotient bit per clock. A start/busy/done handshake lets a controller FSM issue one division at a time.

## Interface
- D_WIDTH1, 16: dividend width, signed two's complement
- D_WIDTH2, 16: divisor width, signed two's complement
- FRAC_SHIFT, 8: left shift applied to the dividend before dividing (extra fractional bits in the quotient)
- Derived: Q_WIDTH = D_WIDTH1+FRAC_SHIFT; M = Q_WIDTH−1 (number of quotient magnitude bits and CALC cycles)

Ports:
- clk  in  1  clock; every register updates on its rising edge
- rst  in  1  reset, synchronous and active-high
- div_start  in  1  request; sampled only in IDLE or DONE
- div_a  in  D_WIDTH1  dividend; sampled with div_start
- div_b  in  D_WIDTH2  divisor; sampled with div_start
- div_busy  out  1  high in CALC and FIX
- div_done  out  1  one-cycle pulse; div_q, div_r and div_dz are valid from this cycle on
- div_q  out  Q_WIDTH  signed quotient, truncated toward zero
- div_r  out  D_WIDTH2  signed remainder of the scaled dividend; carries the dividend's sign
- div_dz  out  1  divide-by-zero flag for the last result

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE/DONE with div_start=1:
  - Latch the sign of a and the sign of b.
  - Latch |a| and |b| as magnitudes of width−1 bits.
  - The most-negative code −2^(W−1) clamps to magnitude 2^(W−1)−1.
  - If |b|=0, go to FIX with dz set. Otherwise clear the partial remainder, load the dividend magnitude shifted left by FRAC_SHIFT, set the counter to M, and go to CALC.
- CALC, one iteration per cycle:
  - Shift the next dividend bit (MSB first) into the partial remainder.
  - If partial remainder ≥ |b|, subtract |b| and shift in quotient bit 1; otherwise shift in 0.
  - Decrement the counter. Go to FIX after the M-th iteration.
- FIX:
  - Quotient sign = sign_a XOR sign_b. Remainder sign = sign_a.
  - Apply two's complement only when the magnitude is nonzero, so a zero result is always all-zero (no negative zero).
  - Register div_q, div_r and div_dz, then go to DONE.
- Divide by zero: div_r=0, div_dz=1. div_q = −2^(Q_WIDTH−1) if a<0, else 2^(Q_WIDTH−1)−1.
- DONE:
  - div_done=1 for one cycle.
  - With no start, go to IDLE. A start in DONE is accepted exactly as in IDLE.
- div_start in CALC or FIX is ignored; there is no queueing.
- Outputs hold their last result until the next FIX overwrites them.
- Quotient magnitude never exceeds Q_WIDTH−1 bits, so there is no overflow path.

## Timing
- Reset:
  - Value: state=IDLE; div_busy=0, div_done=0, div_q=0, div_r=0, div_dz=0; counter and internal registers cleared.
  - Effect: rst overrides everything, including mid-CALC. No div_done is produced for an aborted division. rst and div_start in the same cycle: rst wins.
- Let start be sampled at the end of cycle 0.
- Normal division:
  - CALC in cycles 1..M; FIX in cycle M+1.
  - div_done=1 and new outputs visible in cycle M+2. With defaults, M=23, so done is at cycle 25.
  - div_busy=1 in cycles 1..M+1.
- Divide by zero: FIX in cycle 1; done in cycle 2.
- Back-to-back: a start in the DONE cycle gives the next done M+2 cycles later, for a throughput of one division per M+2 cycles.

## Test plan
- a=100, b=3 (defaults) → done at cycle 25; div_q=8533, div_r=1, div_dz=0; div_busy high cycles 1–24.
- a=−100, b=3 → div_q=−8533, div_r=−1. a=−100, b=−3 → div_q=8533, div_r=−1. a=100, b=−3 → div_q=−8533, div_r=1.
- a=5, b=0 → done at cycle 2; div_q=8388607, div_r=0, div_dz=1. a=−5, b=0 → div_q=0x800000, div_dz=1.
- a=0, b=−7 → div_q=0 and div_r=0, both all-zero bits. a=−32768, b=1 → clamp applies; div_q=−8388352, div_r=0.
- div_start pulsed again at cycle 10 with different operands → ignored; the original result is returned at cycle 25. A new start in the DONE cycle → the second result is done at cycle 50.
- rst asserted at cycle 12 → at the next edge state=IDLE and every output is 0; no div_done pulse follows; a subsequent start completes normally.

Source files
------------

// File: rtl/div_seq_if.sv
// Start/busy/done handshake and operand/result bundle for the sequential divider.
// master = controller issuing divisions, slave = the divider itself.
interface div_seq_if #(
    parameter int D_WIDTH1   = 16,
    parameter int D_WIDTH2   = 16,
    parameter int FRAC_SHIFT = 8
) ();
    localparam int Q_WIDTH = D_WIDTH1 + FRAC_SHIFT;

    logic                div_start;
    logic [D_WIDTH1-1:0] div_a;
    logic [D_WIDTH2-1:0] div_b;
    logic                div_busy;
    logic                div_done;
    logic [Q_WIDTH-1:0]  div_q;
    logic [D_WIDTH2-1:0] div_r;
    logic                div_dz;

    modport master (
        output div_start, div_a, div_b,
        input  div_busy, div_done, div_q, div_r, div_dz
    );

    modport slave (
        input  div_start, div_a, div_b,
        output div_busy, div_done, div_q, div_r, div_dz
    );
endinterface

// File: rtl/div_seq.sv
// Sequential signed fixed-point divider: q = trunc((a << FRAC_SHIFT) / b),
// radix-2 restoring on magnitudes, one quotient bit per clock, sign fixed up at the end.
module div_seq #(
    parameter int D_WIDTH1   = 16,
    parameter int D_WIDTH2   = 16,
    parameter int FRAC_SHIFT = 8
) (
    input  logic     clk,
    input  logic     rst,
    div_seq_if.slave bus
);
    localparam int Q_WIDTH = D_WIDTH1 + FRAC_SHIFT;
    localparam int M       = Q_WIDTH - 1;
    localparam int CW      = $clog2(M + 1);
    localparam int AM      = D_WIDTH1 - 1;
    localparam int BM      = D_WIDTH2 - 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t              state_q, state_d;
    logic                sign_a_q, sign_a_d;
    logic                sign_b_q, sign_b_d;
    logic                dz_flag_q, dz_flag_d;
    logic [BM-1:0]       b_mag_q, b_mag_d;
    logic [M-1:0]        dvd_q, dvd_d;
    logic [M-1:0]        quo_q, quo_d;
    logic [BM-1:0]       rem_q, rem_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [Q_WIDTH-1:0]  res_q_q, res_q_d;
    logic [D_WIDTH2-1:0] res_r_q, res_r_d;
    logic                res_dz_q, res_dz_d;

    logic [AM-1:0]       a_abs;
    logic [BM-1:0]       b_abs;
    logic [BM:0]         trial;
    logic                trial_ge;
    logic [Q_WIDTH-1:0]  q_mag;
    logic [D_WIDTH2-1:0] r_mag;

    // Most-negative code has no positive twin; clamp it to the largest magnitude.
    always_comb begin : magnitudes
        a_abs = bus.div_a[AM-1:0];
        if (bus.div_a[D_WIDTH1-1]) begin
            if (bus.div_a[AM-1:0] == '0) a_abs = {AM{1'b1}};
            else                         a_abs = (~bus.div_a[AM-1:0]) + AM'(1);
        end
        b_abs = bus.div_b[BM-1:0];
        if (bus.div_b[D_WIDTH2-1]) begin
            if (bus.div_b[BM-1:0] == '0) b_abs = {BM{1'b1}};
            else                         b_abs = (~bus.div_b[BM-1:0]) + BM'(1);
        end
    end

    always_comb begin : restoring_step
        trial    = {rem_q, dvd_q[M-1]};
        trial_ge = (trial >= {1'b0, b_mag_q});
        q_mag    = {1'b0, quo_q};
        r_mag    = {1'b0, rem_q};
    end

    always_ff @(posedge clk) begin : state_register
        if (rst) begin
            state_q   <= S_IDLE;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            dz_flag_q <= 1'b0;
            b_mag_q   <= '0;
            dvd_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            res_q_q   <= '0;
            res_r_q   <= '0;
            res_dz_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sign_a_q  <= sign_a_d;
            sign_b_q  <= sign_b_d;
            dz_flag_q <= dz_flag_d;
            b_mag_q   <= b_mag_d;
            dvd_q     <= dvd_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            res_q_q   <= res_q_d;
            res_r_q   <= res_r_d;
            res_dz_q  <= res_dz_d;
        end
    end

    always_comb begin : next_state
        state_d   = state_q;
        sign_a_d  = sign_a_q;
        sign_b_d  = sign_b_q;
        dz_flag_d = dz_flag_q;
        b_mag_d   = b_mag_q;
        dvd_d     = dvd_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        res_q_d   = res_q_q;
        res_r_d   = res_r_q;
        res_dz_d  = res_dz_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.div_start) begin
                    sign_a_d  = bus.div_a[D_WIDTH1-1];
                    sign_b_d  = bus.div_b[D_WIDTH2-1];
                    b_mag_d   = b_abs;
                    rem_d     = '0;
                    quo_d     = '0;
                    dvd_d     = M'(a_abs) << FRAC_SHIFT;
                    cnt_d     = CW'(M);
                    dz_flag_d = (b_abs == '0);
                    state_d   = (b_abs == '0) ? S_FIX : S_CALC;
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                // Remainder after a restoring step is below |b|, so BM bits always hold it.
                rem_d = trial_ge ? (trial[BM-1:0] - b_mag_q) : trial[BM-1:0];
                quo_d = {quo_q[M-2:0], trial_ge};
                dvd_d = dvd_q << 1;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = S_FIX;
            end
            S_FIX: begin
                if (dz_flag_q) begin
                    res_q_d  = sign_a_q ? {1'b1, {(Q_WIDTH-1){1'b0}}} : {1'b0, {(Q_WIDTH-1){1'b1}}};
                    res_r_d  = '0;
                    res_dz_d = 1'b1;
                end else begin
                    // Negate only nonzero magnitudes so a zero result stays all-zero.
                    res_q_d  = ((sign_a_q ^ sign_b_q) && (quo_q != '0))
                               ? (~q_mag) + Q_WIDTH'(1) : q_mag;
                    res_r_d  = (sign_a_q && (rem_q != '0))
                               ? (~r_mag) + D_WIDTH2'(1) : r_mag;
                    res_dz_d = 1'b0;
                end
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin : outputs
        bus.div_busy = (state_q == S_CALC) || (state_q == S_FIX);
        bus.div_done = (state_q == S_DONE);
        bus.div_q    = res_q_q;
        bus.div_r    = res_r_q;
        bus.div_dz   = res_dz_q;
    end
endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: expected results are queued at issue time from an
// integer reference model and checked against the DUT when div_done pulses.
module tb_div_seq;
    localparam int D1 = 16;
    localparam int D2 = 16;
    localparam int FS = 8;
    localparam int QW = D1 + FS;
    localparam int M  = QW - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    div_seq_if #(.D_WIDTH1(D1), .D_WIDTH2(D2), .FRAC_SHIFT(FS)) dif ();

    div_seq #(.D_WIDTH1(D1), .D_WIDTH2(D2), .FRAC_SHIFT(FS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif.slave)
    );

    typedef struct {
        logic signed [63:0] q;
        logic signed [63:0] r;
        logic               dz;
        int                 lat;
        string              tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int a, input int b, input string tag);
        exp_t   e;
        longint ae;
        longint num;
        e.tag = tag;
        ae = (a == -32768) ? -32767 : a;
        if (b == 0) begin
            e.q   = (a < 0) ? -(longint'(1) << (QW - 1)) : (longint'(1) << (QW - 1)) - 1;
            e.r   = 0;
            e.dz  = 1'b1;
            e.lat = 2;
        end else begin
            num   = ae * 256;
            e.q   = num / b;
            e.r   = num % b;
            e.dz  = 1'b0;
            e.lat = M + 2;
        end
        return e;
    endfunction

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    // Called at a negedge; leaves the bench at the negedge of cycle 1.
    task automatic issue(input int a, input int b, input string tag);
        dif.div_start = 1'b1;
        dif.div_a     = 16'(a);
        dif.div_b     = 16'(b);
        sb.push_back(model(a, b, tag));
        cyc = 0;
        tick();
        dif.div_start = 1'b0;
    endtask

    // Leaves the bench at the negedge of the done cycle.
    task automatic wait_done();
        exp_t e;
        e = sb[0];
        while (dif.div_done !== 1'b1 && cyc < 100) begin
            chk({e.tag, ".busy"}, {63'd0, dif.div_busy}, 64'sd1);
            tick();
        end
        if (dif.div_done !== 1'b1) begin
            chk({e.tag, ".done_timeout"}, {63'd0, dif.div_done}, 64'sd1);
            void'(sb.pop_front());
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".latency"}, 64'(cyc), 64'(e.lat));
            chk({e.tag, ".busy_at_done"}, {63'd0, dif.div_busy}, 64'sd0);
            chk({e.tag, ".q"}, 64'($signed(dif.div_q)), e.q);
            chk({e.tag, ".r"}, 64'($signed(dif.div_r)), e.r);
            chk({e.tag, ".dz"}, {63'd0, dif.div_dz}, {63'd0, e.dz});
            $display("txn %s: done@%0d q=%0d r=%0d dz=%0b (exp q=%0d r=%0d dz=%0b)",
                     e.tag, cyc, $signed(dif.div_q), $signed(dif.div_r), dif.div_dz, e.q, e.r, e.dz);
        end
    endtask

    task automatic after_done(input string tag);
        tick();
        chk({tag, ".done_pulse"}, {63'd0, dif.div_done}, 64'sd0);
    endtask

    initial begin
        int          ta[8];
        int          tb_[8];
        string       tt[8];
        logic [15:0] ra;
        logic [15:0] rb;
        bit          saw_done;

        ta = '{100, -100, -100, 100, 5, -5, 0, -32768};
        tb_ = '{3, 3, -3, -3, 0, 0, -7, 1};
        tt = '{"p_p", "n_p", "n_n", "p_n", "dz_p", "dz_n", "zero", "clamp"};

        dif.div_start = 1'b0;
        dif.div_a     = '0;
        dif.div_b     = '0;
        rst           = 1'b1;
        repeat (3) tick();
        chk("reset.busy", {63'd0, dif.div_busy}, 64'sd0);
        chk("reset.done", {63'd0, dif.div_done}, 64'sd0);
        chk("reset.q", 64'($signed(dif.div_q)), 64'sd0);
        chk("reset.r", 64'($signed(dif.div_r)), 64'sd0);
        chk("reset.dz", {63'd0, dif.div_dz}, 64'sd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            issue(ta[i], tb_[i], tt[i]);
            wait_done();
            after_done(tt[i]);
        end

        for (int i = 0; i < 4; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom_range(1, 2000));
            if (i[0]) rb = -rb;
            issue(int'($signed(ra)), int'($signed(rb)), $sformatf("rnd%0d", i));
            wait_done();
            after_done($sformatf("rnd%0d", i));
        end

        // Start during CALC must be ignored; start in DONE must be accepted.
        issue(100, 3, "ign");
        while (cyc < 10) tick();
        dif.div_start = 1'b1;
        dif.div_a     = 16'd7;
        dif.div_b     = 16'd2;
        tick();
        dif.div_start = 1'b0;
        wait_done();
        issue(1234, -57, "b2b");
        wait_done();
        after_done("b2b");

        // Reset mid-CALC, with a simultaneous start that must lose to reset.
        issue(100, 3, "abort");
        while (cyc < 12) tick();
        rst           = 1'b1;
        dif.div_start = 1'b1;
        dif.div_a     = 16'd9;
        dif.div_b     = 16'd1;
        tick();
        rst           = 1'b0;
        dif.div_start = 1'b0;
        chk("abort.busy", {63'd0, dif.div_busy}, 64'sd0);
        chk("abort.done", {63'd0, dif.div_done}, 64'sd0);
        chk("abort.q", 64'($signed(dif.div_q)), 64'sd0);
        chk("abort.r", 64'($signed(dif.div_r)), 64'sd0);
        chk("abort.dz", {63'd0, dif.div_dz}, 64'sd0);
        void'(sb.pop_back());
        saw_done = 1'b0;
        repeat (40) begin
            tick();
            if (dif.div_done === 1'b1 || dif.div_busy === 1'b1) saw_done = 1'b1;
        end
        chk("abort.no_activity", {63'd0, saw_done}, 64'sd0);
        $display("txn abort: reset at cycle 12, outputs cleared");

        issue(-777, 13, "post_rst");
        wait_done();
        after_done("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
